// File: rtl/dclk_defs.sv
// Shared definitions for the digital-clock timekeeping core.
package dclk_defs;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned MIN_SEC_MAX   = 59;
  localparam int unsigned HOURS_PER_DAY = 24;

  localparam logic [DIGIT_W-1:0] BCD_NINE = DIGIT_W'(9);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with clear and combinational carry-out.
module bcd_mod_counter
  import dclk_defs::*;
#(
  parameter int unsigned MOD  = 60,
  parameter int unsigned INIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_T  = DIGIT_W'((MOD - 1) / 10);
  localparam logic [DIGIT_W-1:0] MAX_U  = DIGIT_W'((MOD - 1) % 10);
  localparam logic [DIGIT_W-1:0] INIT_T = DIGIT_W'(INIT / 10);
  localparam logic [DIGIT_W-1:0] INIT_U = DIGIT_W'(INIT % 10);

  logic at_max;

  assign at_max = (tens == MAX_T) && (units == MAX_U);
  assign carry  = en && at_max;

  // Clear outranks increment so a coincident tick cannot leave a nonzero value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens  <= INIT_T;
      units <= INIT_U;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (en) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == BCD_NINE) begin
        tens  <= tens + DIGIT_W'(1);
        units <= '0;
      end else begin
        units <= units + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dclk_time_counter.sv
// Timekeeping core: BCD hh:mm:ss in 24 h format with a three-state set-mode FSM.
module dclk_time_counter
  import dclk_defs::*;
#(
  parameter int unsigned HOUR_MOD  = HOURS_PER_DAY,
  parameter int unsigned INIT_HOUR = 0
) (
  input  logic               high,
  input  logic               rst,
  input  logic               sec_tick,
  input  logic               mode_p,
  input  logic               inc_p,
  output logic [DIGIT_W-1:0] hour_t,
  output logic [DIGIT_W-1:0] hour_u,
  output logic [DIGIT_W-1:0] min_t,
  output logic [DIGIT_W-1:0] min_u,
  output logic [DIGIT_W-1:0] sec_t,
  output logic [DIGIT_W-1:0] sec_u,
  output logic               set_hour,
  output logic               set_min,
  output logic               blink,
  output logic               chime
);

  state_t state;

  logic in_run;
  logic inc_ok;
  logic sec_en, sec_clr, sec_carry;
  logic min_en, min_carry;
  logic hour_en, day_wrap_unused;

  assign in_run = (state == ST_RUN);
  // A mode press in the same cycle swallows the increment.
  assign inc_ok = inc_p && !mode_p;

  assign sec_en  = in_run && sec_tick;
  assign sec_clr = in_run && mode_p;
  assign min_en  = (in_run && sec_carry) || ((state == ST_SET_MIN) && inc_ok);
  assign hour_en = (in_run && min_carry) || ((state == ST_SET_HOUR) && inc_ok);

  bcd_mod_counter #(.MOD(MIN_SEC_MAX + 1), .INIT(0)) u_sec (
    .clk   (high),
    .rst   (rst),
    .en    (sec_en),
    .clr   (sec_clr),
    .tens  (sec_t),
    .units (sec_u),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_SEC_MAX + 1), .INIT(0)) u_min (
    .clk   (high),
    .rst   (rst),
    .en    (min_en),
    .clr   (1'b0),
    .tens  (min_t),
    .units (min_u),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD), .INIT(INIT_HOUR)) u_hour (
    .clk   (high),
    .rst   (rst),
    .en    (hour_en),
    .clr   (1'b0),
    .tens  (hour_t),
    .units (hour_u),
    .carry (day_wrap_unused)
  );

  // Mode FSM with registered flags; blink follows every tick, chime only RUN minute wraps.
  always_ff @(posedge high) begin
    if (rst) begin
      state    <= ST_RUN;
      set_hour <= 1'b0;
      set_min  <= 1'b0;
      blink    <= 1'b0;
      chime    <= 1'b0;
    end else begin
      blink <= blink ^ sec_tick;
      chime <= in_run && min_carry;
      if (mode_p) begin
        unique case (state)
          ST_RUN: begin
            state    <= ST_SET_HOUR;
            set_hour <= 1'b1;
            set_min  <= 1'b0;
          end
          ST_SET_HOUR: begin
            state    <= ST_SET_MIN;
            set_hour <= 1'b0;
            set_min  <= 1'b1;
          end
          default: begin
            state    <= ST_RUN;
            set_hour <= 1'b0;
            set_min  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dclk_time_counter.sv
// Scoreboard bench for dclk_time_counter using directed, hand-computed vectors.
module tb_dclk_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       mode_p = 1'b0;
  logic       inc_p = 1'b0;
  logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic       set_hour, set_min, blink, chime;

  typedef logic [27:0] obs_t;  // {hh, mm, ss BCD, set_hour, set_min, blink, chime}

  typedef struct {
    int    due;
    string name;
    obs_t  exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int chime_cnt = 0;

  dclk_time_counter dut (
    .high     (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .mode_p   (mode_p),
    .inc_p    (inc_p),
    .hour_t   (hour_t),
    .hour_u   (hour_u),
    .min_t    (min_t),
    .min_u    (min_u),
    .sec_t    (sec_t),
    .sec_u    (sec_u),
    .set_hour (set_hour),
    .set_min  (set_min),
    .blink    (blink),
    .chime    (chime)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input int h, input int m, input int s,
                              input logic sh, input logic sm, input logic b, input logic c);
    mk = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
          sh, sm, b, c};
  endfunction

  task automatic drive(input logic r, input logic t, input logic m, input logic i);
    @(posedge clk);
    #1;
    rst      = r;
    sec_tick = t;
    mode_p   = m;
    inc_p    = i;
  endtask

  // Expected outputs after the edge that samples the inputs just driven.
  task automatic expect_next(input string name, input obs_t exp);
    sb_entry_t e;
    e.due  = cyc + 1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge and retires due scoreboard entries.
  always @(negedge clk) begin
    obs_t got;
    got = {hour_t, hour_u, min_t, min_u, sec_t, sec_u, set_hour, set_min, blink, chime};
    if (!rst && chime) chime_cnt++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++;
        $display("FAIL %s: entry missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got hh:mm:ss=%h%h:%h%h:%h%h sh=%b sm=%b blink=%b chime=%b, expected %h flags=%b",
                 e.name, got[27:24], got[23:20], got[19:16], got[15:12], got[11:8], got[7:4],
                 got[3], got[2], got[1], got[0], e.exp[27:4], e.exp[3:0]);
      end
    end
  end

  initial begin
    // Reset
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    expect_next("reset", mk(0, 0, 0, 0, 0, 0, 0));

    // 61 ticks in RUN
    repeat (61) drive(0, 1, 0, 0);
    expect_next("run_61_ticks", mk(0, 1, 1, 0, 0, 1, 0));

    // Preload 23:59:58 via set mode
    drive(0, 0, 1, 0);
    expect_next("enter_set_hour_clears_sec", mk(0, 1, 0, 1, 0, 1, 0));
    repeat (23) drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    repeat (58) drive(0, 0, 0, 1);
    expect_next("preload_23_59", mk(23, 59, 0, 0, 1, 1, 0));
    drive(0, 0, 1, 0);
    expect_next("back_to_run", mk(23, 59, 0, 0, 0, 1, 0));
    repeat (58) drive(0, 1, 0, 0);
    expect_next("at_23_59_58", mk(23, 59, 58, 0, 0, 1, 0));
    drive(0, 1, 0, 0);
    expect_next("at_23_59_59", mk(23, 59, 59, 0, 0, 0, 0));
    drive(0, 1, 0, 0);
    expect_next("midnight_chime", mk(0, 0, 0, 0, 0, 1, 1));
    drive(0, 0, 0, 0);
    expect_next("chime_one_cycle", mk(0, 0, 0, 0, 0, 1, 0));

    // Hour setting with wrap, tick during set mode
    drive(0, 0, 1, 0);
    expect_next("set_hour_entry", mk(0, 0, 0, 1, 0, 1, 0));
    drive(0, 0, 0, 1);
    expect_next("hour_inc_01", mk(1, 0, 0, 1, 0, 1, 0));
    drive(0, 1, 0, 1);
    expect_next("tick_with_inc", mk(2, 0, 0, 1, 0, 0, 0));
    repeat (21) drive(0, 0, 0, 1);
    expect_next("hour_23", mk(23, 0, 0, 1, 0, 0, 0));
    drive(0, 0, 0, 1);
    expect_next("hour_wrap_00", mk(0, 0, 0, 1, 0, 0, 0));
    drive(0, 0, 0, 1);
    expect_next("hour_after_wrap_01", mk(1, 0, 0, 1, 0, 0, 0));
    drive(0, 1, 0, 0);
    expect_next("tick_frozen_in_set", mk(1, 0, 0, 1, 0, 1, 0));

    // mode+inc together: transition wins, minute untouched
    drive(0, 0, 1, 1);
    expect_next("mode_inc_to_set_min", mk(1, 0, 0, 0, 1, 1, 0));
    repeat (59) drive(0, 0, 0, 1);
    expect_next("min_59", mk(1, 59, 0, 0, 1, 1, 0));
    drive(0, 0, 0, 1);
    expect_next("min_wrap_no_carry", mk(1, 0, 0, 0, 1, 1, 0));
    drive(0, 0, 1, 0);
    expect_next("set_min_to_run", mk(1, 0, 0, 0, 0, 1, 0));
    drive(0, 1, 0, 0);
    expect_next("run_resumes", mk(1, 0, 1, 0, 0, 0, 0));

    // Tick + mode + inc from RUN: tick applied, clear wins, hour unchanged
    drive(0, 1, 1, 1);
    expect_next("tick_mode_inc_run", mk(1, 0, 0, 1, 0, 1, 0));
    repeat (11) drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    repeat (34) drive(0, 0, 0, 1);
    expect_next("at_12_34_set_min", mk(12, 34, 0, 0, 1, 1, 0));

    // Reset mid set mode
    drive(1, 0, 0, 0);
    expect_next("reset_in_set_min", mk(0, 0, 0, 0, 0, 0, 0));
    drive(0, 1, 0, 0);
    expect_next("run_after_reset", mk(0, 0, 1, 0, 0, 1, 0));
    drive(0, 0, 0, 1);
    expect_next("inc_ignored_in_run", mk(0, 0, 1, 0, 0, 1, 0));
    drive(0, 0, 1, 1);
    expect_next("mode_inc_from_run", mk(0, 0, 0, 1, 0, 1, 0));
    drive(0, 0, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries never retired, expected 0", sb_q.size());
    end

    checks++;
    if (chime_cnt != 1) begin
      failures++;
      $display("FAIL chime_count: got %0d pulses, expected 1", chime_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
